regbank32_wr_n: RTL and testbench

//  Write side of the 32-entry register bank; mux32to1_n is the read side.
//  - Decodes a 5-bit write address to a one-hot enable and stores n-bit data.
//  - Exposes every entry in parallel on data_o, which feeds the read muxes.
//  - Includes a sequenced bank-clear engine that zeroes one entry per cycle.

---
 rtl/regbank_pkg.sv | 12 +
 rtl/decoder_n.sv | 18 +
 rtl/regbank32_wr_n.sv | 108 ++++++++++
 tb/tb_regbank32_wr_n.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/regbank_pkg.sv
// Shared types for the register-bank write side: FSM state and an entry-writability helper.
// Pure declarations; no latency or backpressure of its own.
package regbank_pkg;

  typedef enum logic {IDLE, CLEAR} rb_state_t;

  // Entry 0 is a hardwired zero when zero_r0 is set; every other entry is real storage.
  function automatic bit entry_writable(input int k, input bit zero_r0);
    return !(zero_r0 && (k == 0));
  endfunction

endpackage

// File: rtl/decoder_n.sv
// Binary-to-one-hot decoder gated by an enable; all outputs low when en_i is low.
// Purely combinational, zero latency, no backpressure.
module decoder_n #(
  parameter int address = 5
) (
  input  logic                      en_i,
  input  logic [address-1:0]        addr_i,
  output logic [(2**address)-1:0]   onehot_o
);

  always_comb begin
    onehot_o = '0;
    if (en_i) begin
      onehot_o[addr_i] = 1'b1;
    end
  end

endmodule

// File: rtl/regbank32_wr_n.sv
// Write side of the 32-entry bank: one-hot decoded writes plus a one-entry-per-cycle clear engine.
// Write latency 1 (ack one cycle later); while busy_o is high, writes are refused, not queued.
module regbank32_wr_n
  import regbank_pkg::*;
#(
  parameter int n       = 4,
  parameter int address = 5,
  parameter int m       = 32,
  parameter bit ZERO_R0 = 1'b1
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      wr_en_i,
  input  logic [address-1:0]        wr_addr_i,
  input  logic [n-1:0]              wr_data_i,
  input  logic                      clr_i,
  output logic [m-1:0][n-1:0]       data_o,
  output logic                      busy_o,
  output logic                      wr_ack_o
);

  if (m != (1 << address)) begin : g_bad_m
    $error("regbank32_wr_n: m must equal 2**address");
  end

  localparam logic [address-1:0] LAST = address'(m - 1);

  rb_state_t            state, state_nxt;
  logic [address-1:0]   cnt, cnt_nxt;
  logic                 ack_nxt;
  logic                 dec_en;
  logic [address-1:0]   dec_addr;
  logic [n-1:0]         dec_dat;
  logic [m-1:0]         sel;

  // The clear engine borrows the write decoder: address and data are muxed, never both active.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    ack_nxt   = 1'b0;
    dec_en    = 1'b0;
    dec_addr  = wr_addr_i;
    dec_dat   = wr_data_i;
    unique case (state)
      IDLE: begin
        if (clr_i) begin
          state_nxt = CLEAR;
          cnt_nxt   = '0;
        end else if (wr_en_i) begin
          dec_en  = 1'b1;
          ack_nxt = 1'b1;
        end
      end
      CLEAR: begin
        dec_en   = 1'b1;
        dec_addr = cnt;
        dec_dat  = '0;
        if (cnt == LAST) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + address'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= IDLE;
      cnt      <= '0;
      wr_ack_o <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      wr_ack_o <= ack_nxt;
    end
  end

  assign busy_o = (state == CLEAR);

  decoder_n #(.address(address)) u_dec (
    .en_i     (dec_en),
    .addr_i   (dec_addr),
    .onehot_o (sel)
  );

  for (genvar k = 0; k < m; k++) begin : g_entry
    if (entry_writable(k, ZERO_R0)) begin : g_flop
      logic [n-1:0] q;
      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          q <= '0;
        end else if (sel[k]) begin
          q <= dec_dat;
        end
      end
      assign data_o[k] = q;
    end else begin : g_zero
      // A write to a hardwired-zero entry is still acked; only the data is dropped.
      logic unused_sel;
      assign unused_sel = sel[k];
      assign data_o[k]  = '0;
    end
  end

endmodule

// File: tb/tb_regbank32_wr_n.sv
// Randomised bench for regbank32_wr_n against an edge-indexed behavioural model of the bank.
module tb_regbank32_wr_n;

  localparam int N  = 4;
  localparam int A  = 5;
  localparam int M  = 32;
  localparam bit Z0 = 1'b1;

  logic             clk     = 1'b0;
  logic             rst     = 1'b1;
  logic             wr_en   = 1'b0;
  logic [A-1:0]     wr_addr = '0;
  logic [N-1:0]     wr_data = '0;
  logic             clr     = 1'b0;
  logic [M-1:0][N-1:0] data_o;
  logic             busy_o;
  logic             wr_ack_o;

  int n_cmp = 0;
  int n_bad = 0;
  bit check_en = 1'b0;

  // Model: bank contents, and clear progress expressed as the edge number the clear began on.
  logic [N-1:0] mem [M];
  bit  clearing;
  bit  ack_m;
  int  edge_n;
  int  clr_edge;

  regbank32_wr_n #(.n(N), .address(A), .m(M), .ZERO_R0(Z0)) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .wr_en_i   (wr_en),
    .wr_addr_i (wr_addr),
    .wr_data_i (wr_data),
    .clr_i     (clr),
    .data_o    (data_o),
    .busy_o    (busy_o),
    .wr_ack_o  (wr_ack_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_vec(input string name, input logic [M*N-1:0] act, input logic [M*N-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or posedge rst) begin
    int k;
    if (rst) begin
      for (int i = 0; i < M; i++) mem[i] = '0;
      clearing = 1'b0;
      ack_m    = 1'b0;
      edge_n   = 0;
      clr_edge = 0;
    end else begin
      edge_n++;
      if (clearing) begin
        k = edge_n - clr_edge - 1;
        mem[k] = '0;
        ack_m  = 1'b0;
        if (k == M - 1) clearing = 1'b0;
      end else if (clr) begin
        clearing = 1'b1;
        clr_edge = edge_n;
        ack_m    = 1'b0;
      end else if (wr_en) begin
        if (!(Z0 && wr_addr == 0)) mem[wr_addr] = wr_data;
        ack_m = 1'b1;
      end else begin
        ack_m = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    logic [M-1:0][N-1:0] ev;
    if (check_en && !rst) begin
      for (int i = 0; i < M; i++) ev[i] = mem[i];
      chk("busy", int'(busy_o), int'(clearing));
      chk("ack", int'(wr_ack_o), int'(ack_m));
      chk_vec("data", data_o, ev);
    end
  end

  task automatic apply(input bit we, input int addr, input int dat, input bit c);
    wr_en   = we;
    wr_addr = A'(addr);
    wr_data = N'(dat);
    clr     = c;
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int busy_cnt;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_en = 1'b1;

    chk_vec("reset_data", data_o, '0);
    chk("reset_busy", int'(busy_o), 0);
    chk("reset_ack", int'(wr_ack_o), 0);

    apply(1'b1, 7, 4'hA, 1'b0);
    chk("w7_data", int'(data_o[7]), 10);
    chk("w7_ack", int'(wr_ack_o), 1);
    chk("w7_model", int'(mem[7]), 10);
    apply(1'b0, 0, 0, 1'b0);
    chk("w7_ack_pulse", int'(wr_ack_o), 0);

    apply(1'b1, 0, 4'hF, 1'b0);
    chk("r0_data", int'(data_o[0]), 0);
    chk("r0_ack", int'(wr_ack_o), 1);

    for (int k = 0; k < M; k++) apply(1'b1, k, k % 16, 1'b0);
    apply(1'b0, 0, 0, 1'b0);
    chk("fill_5", int'(data_o[5]), 5);
    chk("fill_31", int'(data_o[31]), 15);
    chk("fill_0", int'(data_o[0]), 0);

    // Clear requested together with a write; then keep writing addr 3 while busy.
    apply(1'b1, 3, 5, 1'b1);
    chk("clr_wr_noack", int'(wr_ack_o), 0);
    busy_cnt = busy_o ? 1 : 0;
    for (int j = 1; j < 40; j++) begin
      apply(busy_o, 3, 5, 1'b0);
      if (j == 5) begin
        chk("clr_mid_4", int'(data_o[4]), 0);
        chk("clr_mid_5", int'(data_o[5]), 5);
        chk("clr_mid_31", int'(data_o[31]), 15);
      end
      if (!busy_o) break;
      busy_cnt++;
    end
    chk("clr_busy_cycles", busy_cnt, 32);
    chk_vec("clr_all_zero", data_o, '0);
    chk("clr_d3", int'(data_o[3]), 0);
    chk("clr_noack", int'(wr_ack_o), 0);

    for (int i = 0; i < 400; i++) begin
      apply($urandom_range(0, 3) != 0, int'($urandom_range(0, M - 1)),
            int'($urandom_range(0, 15)), $urandom_range(0, 99) < 3);
    end
    for (int i = 0; i < 40 && busy_o; i++) apply(1'b0, 0, 0, 1'b0);
    chk("rand_idle", int'(busy_o), 0);

    apply(1'b1, 9, 7, 1'b0);
    apply(1'b0, 0, 0, 1'b1);
    repeat (9) apply(1'b0, 0, 0, 1'b0);
    chk("c10_busy", int'(busy_o), 1);
    chk("c10_d9", int'(data_o[9]), 7);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk_vec("arst_data", data_o, '0);
    chk("arst_busy", int'(busy_o), 0);
    chk("arst_ack", int'(wr_ack_o), 0);
    @(negedge clk);
    rst = 1'b0;
    apply(1'b1, 9, 6, 1'b0);
    chk("post_rst_ack", int'(wr_ack_o), 1);
    chk("post_rst_d9", int'(data_o[9]), 6);
    chk("post_rst_busy", int'(busy_o), 0);
    apply(1'b0, 0, 0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
